bank_conflict_scheduler: RTL and testbench
==========================================

# bank_conflict_scheduler

Arbitrates four word-interleaved requesters onto four single-ported memory banks, sitting in front of the 4x4 bank crossbar. Each cycle it grants at most one requester per bank, chosen by a per-bank round-robin pointer, and drives bank addresses and enables. It denies the losing requesters, which hold and retry. It tracks each grant through a fixed-latency return pipeline, routes the returning bank word back to the originating port, and counts conflict cycles for performance monitoring.

## Interface
- ADDRW, 16, requester word-address width; bank = addr[1:0], bank row = addr[ADDRW-1:2]
- WL, 32, data word width
- LAT, 2, bank read latency in enabled cycles; legal range 1..4
- CNTW, 16, conflict counter width

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  global advance; low freezes all state, grants, and responses
- req_valid  in  4  per-port request valid
- req_addr0..req_addr3  in  ADDRW each  per-port word address
- req_ready  out  4  per-port grant this cycle (combinational)
- bank_en  out  4  per-bank read enable (combinational)
- bank_addr0..bank_addr3  out  ADDRW-2 each  per-bank row address
- q0..q3  in  WL each  bank read data, valid LAT enabled cycles after bank_en
- rsp_valid  out  4  per-port response valid
- rsp_data0..rsp_data3  out  WL each  per-port response word
- conflict_cnt  out  CNTW  saturating count of enabled cycles with at least one denied valid request

## Operation
- Candidates for bank b: ports i with req_valid[i]=1 and req_addr_i[1:0]=b.
- Winner for bank b: the first candidate in cyclic order ptr[b], ptr[b]+1, … (mod 4).
- req_ready[i] = ena & !rst & (port i is the winner of its bank). At most one ready per bank.
- bank_en[b] = 1 iff bank b has a winner and the same ena/rst qualification applies.
- bank_addr_b = winner's addr[ADDRW-2+1:2]. When bank_en[b]=0, bank_addr_b = 0.
- Pointer update on rising clk with ena=1: if bank b granted port w, ptr[b] <= (w+1) mod 4. Otherwise ptr[b] holds.
- Requester rule: a denied port keeps req_valid and req_addr stable until granted. The block does not check this.
- Return pipeline per port: LAT stages of {vld, bank[1:0]}. The stage-0 input is {req_ready[i], req_addr_i[1:0]}. All stages shift when ena=1 and hold when ena=0.
- rsp_valid[i] = ena & tail_vld[i].
- rsp_data_i = q[tail_bank_i], a combinational mux that is always driven.
- conflict_cnt increments when ena=1 and (req_valid & ~req_ready) != 0. It saturates at 2^CNTW-1 and never wraps.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the system) forces:
  - ptr[0..3]=0, all pipeline vld=0, all pipeline bank=0, conflict_cnt=0.
  - While rst=1: req_ready=0, bank_en=0, rsp_valid=0, bank_addr=0.
- Reset mid-operation discards all in-flight responses; no rsp_valid is issued for them.
- Latency: a grant at enabled cycle T produces rsp_valid on the same port at enabled cycle T+LAT. Cycles with ena=0 do not count.
- Full throughput: 4 grants per cycle when all four valid ports target distinct banks.
- With 4 ports on one bank, each port is granted exactly once in every 4 consecutive enabled cycles.
- Simultaneous grant and response on a port is legal (pipelined); the pipeline never back-pressures.
- ena=0: req_ready=0, bank_en=0, rsp_valid=0; pointers, pipeline, and counter hold.

## Test plan
- Distinct banks: ports 0..3 valid with addresses 0x0010, 0x0021, 0x0032, 0x0043 -> req_ready=4'b1111, bank_en=4'b1111, bank_addr0=0x004 and bank_addr3=0x010. Two cycles later rsp_valid=4'b1111 with rsp_data_i = q[i]; conflict_cnt stays 0.
- Full conflict: all ports hold bank 2 for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; each port sees rsp_valid twice, each 2 cycles after its grant; conflict_cnt=8.
- Fairness after partial grant: ptr[1]=3 with ports 0 and 2 requesting bank 1 -> port 0 granted first, then port 2.
- ena freeze: grant in cycle T, then ena=0 for 3 cycles -> no rsp_valid during the freeze. rsp_valid arrives on the second enabled cycle after the grant, and pointers are unchanged across the freeze.
- Reset mid-flight: assert rst one cycle after a 4-port grant -> all outputs 0 immediately. After release, no stale rsp_valid appears; ptr=0 and conflict_cnt=0.
- Saturation: CNTW=4 with a sustained conflict for 20 cycles -> conflict_cnt reaches 15 and holds at 15.

Source files
------------

// File: rtl/bank_conflict_scheduler.sv
// bank_conflict_scheduler: per-bank round-robin arbitration of four
// word-interleaved requesters onto four single-ported banks, with a
// fixed-latency return pipeline per port and a saturating conflict counter.
module bank_conflict_scheduler #(
  parameter int ADDRW = 16,
  parameter int WL    = 32,
  parameter int LAT   = 2,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [3:0]       req_valid,
  input  logic [ADDRW-1:0] req_addr0,
  input  logic [ADDRW-1:0] req_addr1,
  input  logic [ADDRW-1:0] req_addr2,
  input  logic [ADDRW-1:0] req_addr3,
  output logic [3:0]       req_ready,
  output logic [3:0]       bank_en,
  output logic [ADDRW-3:0] bank_addr0,
  output logic [ADDRW-3:0] bank_addr1,
  output logic [ADDRW-3:0] bank_addr2,
  output logic [ADDRW-3:0] bank_addr3,
  input  logic [WL-1:0]    q0,
  input  logic [WL-1:0]    q1,
  input  logic [WL-1:0]    q2,
  input  logic [WL-1:0]    q3,
  output logic [3:0]       rsp_valid,
  output logic [WL-1:0]    rsp_data0,
  output logic [WL-1:0]    rsp_data1,
  output logic [WL-1:0]    rsp_data2,
  output logic [WL-1:0]    rsp_data3,
  output logic [CNTW-1:0]  conflict_cnt
);

  localparam int RW = ADDRW - 2;

  logic [ADDRW-1:0] addr_s [4];
  logic [WL-1:0]    q_s    [4];
  logic [1:0]       ptr_q  [4];
  logic [1:0]       ptr_d  [4];
  logic [3:0]       win_vld_s;
  logic [1:0]       win_s  [4];
  logic [1:0]       idx_s;
  logic             qual_s;
  logic [RW-1:0]    baddr_s [4];
  logic [WL-1:0]    rdata_s [4];
  logic [3:0]       vld_q  [LAT];
  logic [1:0]       bank_q [LAT][4];
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;

  // Grants only exist while the block is enabled and out of reset.
  assign qual_s = ena & ~rst;

  // Gather the per-port/per-bank buses into arrays for indexed access.
  always_comb begin
    addr_s[0] = req_addr0;
    addr_s[1] = req_addr1;
    addr_s[2] = req_addr2;
    addr_s[3] = req_addr3;
    q_s[0]    = q0;
    q_s[1]    = q1;
    q_s[2]    = q2;
    q_s[3]    = q3;
  end

  // Per-bank winner search: first candidate at or after the bank pointer.
  always_comb begin
    win_vld_s = 4'b0000;
    idx_s     = 2'd0;
    for (int b = 0; b < 4; b++) begin
      win_s[b] = 2'd0;
      for (int k = 0; k < 4; k++) begin
        idx_s = ptr_q[b] + 2'(k);
        if (!win_vld_s[b] && req_valid[idx_s] && (addr_s[idx_s][1:0] == 2'(b))) begin
          win_vld_s[b] = 1'b1;
          win_s[b]     = idx_s;
        end else begin
          win_vld_s[b] = win_vld_s[b];
        end
      end
    end
  end

  // Qualified grants, bank enables/addresses and next pointer values.
  always_comb begin
    req_ready = 4'b0000;
    bank_en   = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      baddr_s[b] = '0;
      ptr_d[b]   = ptr_q[b];
      if (qual_s && win_vld_s[b]) begin
        bank_en[b]          = 1'b1;
        req_ready[win_s[b]] = 1'b1;
        baddr_s[b]          = addr_s[win_s[b]][ADDRW-1:2];
        ptr_d[b]            = win_s[b] + 2'd1;
      end else begin
        ptr_d[b] = ptr_q[b];
      end
    end
  end

  assign bank_addr0 = baddr_s[0];
  assign bank_addr1 = baddr_s[1];
  assign bank_addr2 = baddr_s[2];
  assign bank_addr3 = baddr_s[3];

  // Conflict counter next state: count denied cycles, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (ena && ((req_valid & ~req_ready) != 4'b0000) && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Round-robin pointers and conflict counter, advancing only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) ptr_q[b] <= 2'd0;
      cnt_q <= '0;
    end else if (ena) begin
      for (int b = 0; b < 4; b++) ptr_q[b] <= ptr_d[b];
      cnt_q <= cnt_d;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // Return pipeline: remembers which bank each grant went to for LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        vld_q[s] <= 4'b0000;
        for (int p = 0; p < 4; p++) bank_q[s][p] <= 2'd0;
      end
    end else if (ena) begin
      vld_q[0] <= req_ready;
      for (int p = 0; p < 4; p++) bank_q[0][p] <= addr_s[p][1:0];
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        for (int p = 0; p < 4; p++) bank_q[s][p] <= bank_q[s-1][p];
      end
    end else begin
      vld_q[0] <= vld_q[0];
    end
  end

  // Response data steering: each port reads the bank its tail entry names.
  always_comb begin
    for (int p = 0; p < 4; p++) rdata_s[p] = q_s[bank_q[LAT-1][p]];
  end

  assign rsp_valid    = {4{ena}} & vld_q[LAT-1];
  assign rsp_data0    = rdata_s[0];
  assign rsp_data1    = rdata_s[1];
  assign rsp_data2    = rdata_s[2];
  assign rsp_data3    = rdata_s[3];
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bank_conflict_scheduler.sv
// Table-driven bench for bank_conflict_scheduler with a response scoreboard.
module tb_bank_conflict_scheduler;

  localparam int LAT = 2;

  typedef struct {
    logic             rst;
    logic             ena;
    logic [3:0]       valid;
    logic [3:0][15:0] a;
    logic [3:0]       rdy;
    logic [3:0]       en;
    logic [3:0][13:0] ba;
    int               cnt;
  } vec_t;

  typedef struct {
    int due;
    int port;
    int bank;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [15:0] req_addr [4];
  logic [31:0] q_in [4];
  logic [3:0]  ready, en, rv;
  logic [13:0] ba [4];
  logic [31:0] rd [4];
  logic [15:0] cnt;
  logic [3:0]  s_ready, s_en, s_rv;
  logic [13:0] s_ba [4];
  logic [31:0] s_rd [4];
  logic [3:0]  s_cnt;

  vec_t tbl [64];
  int   n = 0;
  sb_t  sb [$];
  int   ecyc = 0;
  int   cur = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bank_conflict_scheduler #(.ADDRW(16), .WL(32), .LAT(LAT), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid),
    .req_addr0(req_addr[0]), .req_addr1(req_addr[1]), .req_addr2(req_addr[2]), .req_addr3(req_addr[3]),
    .req_ready(ready), .bank_en(en),
    .bank_addr0(ba[0]), .bank_addr1(ba[1]), .bank_addr2(ba[2]), .bank_addr3(ba[3]),
    .q0(q_in[0]), .q1(q_in[1]), .q2(q_in[2]), .q3(q_in[3]),
    .rsp_valid(rv), .rsp_data0(rd[0]), .rsp_data1(rd[1]), .rsp_data2(rd[2]), .rsp_data3(rd[3]),
    .conflict_cnt(cnt)
  );

  bank_conflict_scheduler #(.ADDRW(16), .WL(32), .LAT(LAT), .CNTW(4)) dut_sat (
    .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid),
    .req_addr0(req_addr[0]), .req_addr1(req_addr[1]), .req_addr2(req_addr[2]), .req_addr3(req_addr[3]),
    .req_ready(s_ready), .bank_en(s_en),
    .bank_addr0(s_ba[0]), .bank_addr1(s_ba[1]), .bank_addr2(s_ba[2]), .bank_addr3(s_ba[3]),
    .q0(q_in[0]), .q1(q_in[1]), .q2(q_in[2]), .q3(q_in[3]),
    .rsp_valid(s_rv), .rsp_data0(s_rd[0]), .rsp_data1(s_rd[1]), .rsp_data2(s_rd[2]), .rsp_data3(s_rd[3]),
    .conflict_cnt(s_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, cur, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [3:0] v,
                     input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3,
                     input logic [3:0] rdy, input logic [3:0] be,
                     input logic [13:0] b0, input logic [13:0] b1, input logic [13:0] b2, input logic [13:0] b3,
                     input int c);
    tbl[n].rst   = r;
    tbl[n].ena   = e;
    tbl[n].valid = v;
    tbl[n].a     = {a3, a2, a1, a0};
    tbl[n].rdy   = rdy;
    tbl[n].en    = be;
    tbl[n].ba    = {b3, b2, b1, b0};
    tbl[n].cnt   = c;
    n++;
  endtask

  task automatic idle(input int c);
    add(1'b0, 1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 14'h0, 14'h0, 14'h0, 14'h0, c);
  endtask

  task automatic check_outs(input string tag, input vec_t v, input logic [3:0] a_rdy,
                            input logic [3:0] a_en, input logic [13:0] a_ba [4],
                            input logic [3:0] a_rv, input logic [31:0] a_rd [4],
                            input logic [3:0] e_rv, input logic [31:0] e_rd [4]);
    chk({tag, "_req_ready"}, 64'(a_rdy), 64'(v.rdy));
    chk({tag, "_bank_en"}, 64'(a_en), 64'(v.en));
    for (int b = 0; b < 4; b++) chk({tag, "_bank_addr"}, 64'(a_ba[b]), 64'(v.ba[b]));
    chk({tag, "_rsp_valid"}, 64'(a_rv), 64'(e_rv));
    for (int p = 0; p < 4; p++)
      if (e_rv[p]) chk({tag, "_rsp_data"}, 64'(a_rd[p]), 64'(e_rd[p]));
  endtask

  initial begin
    vec_t        v;
    logic [3:0]  exp_rv;
    logic [31:0] exp_rd [4];
    int          sat_exp;

    for (int p = 0; p < 4; p++) begin
      req_addr[p] = 16'h0;
      q_in[p]     = 32'h0;
    end

    // Reset with live requests, then four distinct banks and drain.
    add(1'b1, 1'b1, 4'hF, 16'h0010, 16'h0021, 16'h0032, 16'h0043, 4'h0, 4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 0);
    add(1'b0, 1'b1, 4'hF, 16'h0010, 16'h0021, 16'h0032, 16'h0043, 4'hF, 4'hF, 14'h004, 14'h008, 14'h00C, 14'h010, 0);
    idle(0);
    idle(0);
    // Full conflict on bank 2 after a fresh reset.
    add(1'b1, 1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 0);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b1, 4'hF, 16'h0002, 16'h0006, 16'h000A, 16'h000E, 4'(1 << (k % 4)), 4'b0100,
          14'h0, 14'h0, 14'(k % 4), 14'h0, k);
    idle(8);
    idle(8);
    // Fairness: park ptr[1] at 3, then ports 0 and 2 contend on bank 1.
    add(1'b0, 1'b1, 4'b0100, 16'h0, 16'h0, 16'h0005, 16'h0, 4'b0100, 4'b0010, 14'h0, 14'h1, 14'h0, 14'h0, 8);
    add(1'b0, 1'b1, 4'b0101, 16'h0001, 16'h0, 16'h0005, 16'h0, 4'b0001, 4'b0010, 14'h0, 14'h0, 14'h0, 14'h0, 8);
    add(1'b0, 1'b1, 4'b0100, 16'h0, 16'h0, 16'h0005, 16'h0, 4'b0100, 4'b0010, 14'h0, 14'h1, 14'h0, 14'h0, 9);
    idle(9);
    idle(9);
    // ena freeze: grant, three frozen cycles with contention, then resume.
    add(1'b0, 1'b1, 4'b0001, 16'h0010, 16'h0, 16'h0, 16'h0, 4'b0001, 4'b0001, 14'h004, 14'h0, 14'h0, 14'h0, 9);
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b0, 4'b0011, 16'h0000, 16'h0004, 16'h0, 16'h0, 4'h0, 4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 9);
    add(1'b0, 1'b1, 4'b0011, 16'h0000, 16'h0004, 16'h0, 16'h0, 4'b0010, 4'b0001, 14'h001, 14'h0, 14'h0, 14'h0, 9);
    add(1'b0, 1'b1, 4'b0001, 16'h0000, 16'h0, 16'h0, 16'h0, 4'b0001, 4'b0001, 14'h0, 14'h0, 14'h0, 14'h0, 10);
    idle(10);
    idle(10);
    // Reset one cycle after a four-port grant; nothing stale may return.
    add(1'b0, 1'b1, 4'hF, 16'h0010, 16'h0021, 16'h0032, 16'h0043, 4'hF, 4'hF, 14'h004, 14'h008, 14'h00C, 14'h010, 10);
    add(1'b1, 1'b1, 4'hF, 16'h0010, 16'h0021, 16'h0032, 16'h0043, 4'h0, 4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 0);
    idle(0);
    idle(0);
    idle(0);
    add(1'b0, 1'b1, 4'hF, 16'h0011, 16'h0015, 16'h0019, 16'h001D, 4'b0001, 4'b0010, 14'h0, 14'h004, 14'h0, 14'h0, 0);
    idle(1);
    idle(1);
    // Sustained conflict for the saturating 4-bit counter instance.
    add(1'b1, 1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 14'h0, 14'h0, 14'h0, 14'h0, 0);
    for (int k = 0; k < 20; k++)
      add(1'b0, 1'b1, 4'hF, 16'h0002, 16'h0006, 16'h000A, 16'h000E, 4'(1 << (k % 4)), 4'b0100,
          14'h0, 14'h0, 14'(k % 4), 14'h0, k);
    idle(20);
    idle(20);
    idle(20);

    for (int i = 0; i < n; i++) begin
      cur = i;
      v   = tbl[i];
      @(negedge clk);
      rst       = v.rst;
      ena       = v.ena;
      req_valid = v.valid;
      for (int p = 0; p < 4; p++) begin
        req_addr[p] = v.a[p];
        q_in[p]     = 32'hA500_0000 + 32'(p) * 32'h0010_0000 + 32'(ecyc);
      end
      #2;
      exp_rv = 4'h0;
      for (int p = 0; p < 4; p++) exp_rd[p] = 32'h0;
      if (v.rst) sb.delete();
      if (v.ena && !v.rst) begin
        foreach (sb[j]) begin
          if (sb[j].due == ecyc) begin
            exp_rv[sb[j].port] = 1'b1;
            exp_rd[sb[j].port] = q_in[sb[j].bank];
          end
        end
      end
      check_outs("main", v, ready, en, ba, rv, rd, exp_rv, exp_rd);
      check_outs("sat", v, s_ready, s_en, s_ba, s_rv, s_rd, exp_rv, exp_rd);
      chk("conflict_cnt", 64'(cnt), 64'(v.cnt));
      sat_exp = (v.cnt > 15) ? 15 : v.cnt;
      chk("conflict_cnt_sat", 64'(s_cnt), 64'(sat_exp));
      if (v.ena && !v.rst) begin
        while (sb.size() > 0 && sb[0].due == ecyc) void'(sb.pop_front());
        for (int p = 0; p < 4; p++)
          if (v.rdy[p]) sb.push_back('{due: ecyc + LAT, port: p, bank: int'(v.a[p][1:0])});
        ecyc++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
